// File: rtl/input_conditioner.sv
// input_conditioner
// Front-end input stage: synchronizes and debounces the active-low push
// buttons, merges the NIOS keyboard keycode, and produces clean move levels
// plus single-cycle fire/start pulses. Fire is rate-limited by a cooldown
// counter that counts down on rising edges of the (synchronized) frame_clk.
// Optional feature macro: KEYBOARD_INPUT_EN. When defined, keycode is merged
// with the buttons; when undefined, keycode is ignored (kc_q stays 0) and
// start is derived from the fire button alone.
module input_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SHOT_COOLDOWN   = 8
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [2:0] KEY,
    input  logic [7:0] keycode,
    input  logic       frame_clk,
    output logic       left,
    output logic       right,
    output logic       shoot,
    output logic       start,
    output logic       cooldown_active
);

    localparam int DB_W     = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int CD_W_RAW = $clog2(SHOT_COOLDOWN + 1);
    localparam int CD_W     = (CD_W_RAW < 1) ? 1 : CD_W_RAW;

    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CD_W-1:0] CD_LOAD = CD_W'(SHOT_COOLDOWN);

    localparam logic [7:0] KC_RIGHT = 8'd7;
    localparam logic [7:0] KC_LEFT  = 8'd4;
    localparam logic [7:0] KC_START = 8'd40;
    localparam logic [7:0] KC_FIRE  = 8'd44;

    // Button synchronizers hold raw (active-low) values; bit 2 fire, 1 left, 0 right.
    logic [2:0]            key_s1_q, key_s1_d;
    logic [2:0]            key_s2_q, key_s2_d;
    logic [2:0]            db_q, db_d;
    logic [2:0][DB_W-1:0]  db_cnt_q, db_cnt_d;
    logic [7:0]            kc_q, kc_d;
    logic                  fire_q, fire_d;
    logic                  start_lvl_q, start_lvl_d;
    logic                  shoot_q, shoot_d;
    logic                  start_q, start_d;
    logic                  frm_s1_q, frm_s1_d;
    logic                  frm_s2_q, frm_s2_d;
    logic                  frm_prev_q, frm_prev_d;
    logic [CD_W-1:0]       cd_cnt_q, cd_cnt_d;

    logic [2:0] key_act;
    logic       raw_left, raw_right, fire_lvl, start_lvl;
    logic       fire_rise, frm_rise;

    // Synchronizer shifting and keycode capture.
    always_comb begin
        key_s1_d   = KEY;
        key_s2_d   = key_s1_q;
        key_act    = ~key_s2_q;
        frm_s1_d   = frame_clk;
        frm_s2_d   = frm_s1_q;
        frm_prev_d = frm_s2_q;
`ifdef KEYBOARD_INPUT_EN
        kc_d       = keycode;
`else
        // Port kept for a uniform pinout; its value is masked off entirely.
        kc_d       = keycode & 8'h00;
`endif
    end

    // Per-button debounce: flip after DEBOUNCE_CYCLES consecutive disagreeing edges.
    always_comb begin
        // NOTE: every output of a combinational block gets a default first so no latch is inferred.
        db_d     = db_q;
        db_cnt_d = db_cnt_q;
        for (int i = 0; i < 3; i++) begin
            if (key_act[i] == db_q[i]) begin
                db_cnt_d[i] = '0;
            end else if (db_cnt_q[i] == DB_LAST) begin
                db_d[i]     = ~db_q[i];
                db_cnt_d[i] = '0;
            end else begin
                db_cnt_d[i] = db_cnt_q[i] + 1'b1;
            end
        end
    end

    // Merge debounced buttons with the registered keycode into raw levels.
    always_comb begin
        raw_left  = db_q[1] | (kc_q == KC_LEFT);
        raw_right = db_q[0] | (kc_q == KC_RIGHT);
        fire_lvl  = db_q[2] | (kc_q == KC_FIRE);
        start_lvl = fire_lvl | (kc_q == KC_START);
    end

    // Edge detection, fire acceptance and cooldown counter; a load beats a frame decrement.
    always_comb begin
        fire_d      = fire_lvl;
        start_lvl_d = start_lvl;
        fire_rise   = fire_lvl & ~fire_q;
        frm_rise    = frm_s2_q & ~frm_prev_q;
        shoot_d     = fire_rise & (cd_cnt_q == '0);
        start_d     = start_lvl & ~start_lvl_q;
        cd_cnt_d    = cd_cnt_q;
        if (shoot_d) begin
            cd_cnt_d = CD_LOAD;
        end else if (frm_rise && (cd_cnt_q != '0)) begin
            cd_cnt_d = cd_cnt_q - 1'b1;
        end
    end

    // State register: all flops return to released/idle values on reset.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            key_s1_q    <= 3'b111;
            key_s2_q    <= 3'b111;
            db_q        <= 3'b000;
            db_cnt_q    <= '0;
            kc_q        <= 8'h00;
            fire_q      <= 1'b0;
            start_lvl_q <= 1'b0;
            shoot_q     <= 1'b0;
            start_q     <= 1'b0;
            frm_s1_q    <= 1'b0;
            frm_s2_q    <= 1'b0;
            frm_prev_q  <= 1'b0;
            cd_cnt_q    <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples the values from before this edge.
            key_s1_q    <= key_s1_d;
            key_s2_q    <= key_s2_d;
            db_q        <= db_d;
            db_cnt_q    <= db_cnt_d;
            kc_q        <= kc_d;
            fire_q      <= fire_d;
            start_lvl_q <= start_lvl_d;
            shoot_q     <= shoot_d;
            start_q     <= start_d;
            frm_s1_q    <= frm_s1_d;
            frm_s2_q    <= frm_s2_d;
            frm_prev_q  <= frm_prev_d;
            cd_cnt_q    <= cd_cnt_d;
        end
    end

    // Outputs: opposing move requests cancel; pulses come straight from flops.
    always_comb begin
        left            = raw_left & ~raw_right;
        right           = raw_right & ~raw_left;
        shoot           = shoot_q;
        start           = start_q;
        cooldown_active = (cd_cnt_q != '0);
    end

endmodule

// File: tb/tb_input_conditioner.sv
// Self-checking bench for input_conditioner (DEBOUNCE_CYCLES=4, SHOT_COOLDOWN=2).
// Follows the KEYBOARD_INPUT_EN macro so it matches either build.
module tb_input_conditioner;

    localparam int D  = 4;
    localparam int SC = 2;
`ifdef KEYBOARD_INPUT_EN
    localparam bit KB = 1'b1;
`else
    localparam bit KB = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [2:0] KEY;
    logic [7:0] keycode;
    logic       frame_clk;
    logic       left, right, shoot, start, cooldown_active;

    input_conditioner #(.DEBOUNCE_CYCLES(D), .SHOT_COOLDOWN(SC)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .KEY(KEY), .keycode(keycode),
        .frame_clk(frame_clk), .left(left), .right(right), .shoot(shoot),
        .start(start), .cooldown_active(cooldown_active)
    );

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // kh[j]: KEY as sampled j+1 edges ago; a button's synced view lags KEY by two edges.
    // A debounced bit flips once the last D synced views all disagree with it.
    // Cooldown is tracked as "frame edges since the last shot" (saturating at SC).
    logic [2:0] kh [0:D];
    logic       fh [0:2];
    logic [2:0] db_m;
    logic [7:0] kc_m;
    logic       fire_a, fire_b, start_a, start_b;
    int         since_m;
    logic       m_left, m_right, m_shoot, m_start, m_cool;

    function automatic logic lvl_fire(input logic [2:0] db, input logic [7:0] kc);
        return db[2] | (kc == 8'd44);
    endfunction

    task automatic model_outputs();
        logic rl, rr;
        rl = db_m[1] | (kc_m == 8'd4);
        rr = db_m[0] | (kc_m == 8'd7);
        m_left  = rl && !rr;
        m_right = rr && !rl;
        m_cool  = since_m < SC;
    endtask

    task automatic model_reset();
        for (int j = 0; j <= D; j++) kh[j] = 3'b111;
        for (int j = 0; j < 3; j++) fh[j] = 1'b0;
        db_m = 3'b000; kc_m = 8'h00;
        fire_a = 0; fire_b = 0; start_a = 0; start_b = 0;
        since_m = SC;
        m_shoot = 0; m_start = 0;
        model_outputs();
    endtask

    task automatic model_step(input logic [2:0] key, input logic [7:0] kc, input logic frame);
        logic frame_rise, all_diff;
        frame_rise = fh[1] && !fh[2];
        m_shoot = fire_a && !fire_b && (since_m >= SC);
        m_start = start_a && !start_b;
        if (m_shoot) since_m = 0;
        else if (frame_rise && since_m < SC) since_m++;
        fire_b  = fire_a;
        start_b = start_a;
        for (int b = 0; b < 3; b++) begin
            all_diff = 1'b1;
            for (int j = 1; j <= D; j++)
                if (!kh[j][b] == db_m[b]) all_diff = 1'b0;
            if (all_diff) db_m[b] = !db_m[b];
        end
        for (int j = D; j > 0; j--) kh[j] = kh[j-1];
        kh[0] = key;
        fh[2] = fh[1]; fh[1] = fh[0]; fh[0] = frame;
        kc_m = KB ? kc : 8'h00;
        fire_a  = lvl_fire(db_m, kc_m);
        start_a = fire_a | (kc_m == 8'd40);
        model_outputs();
    endtask

    // One clock: model predicts the coming edge, then DUT is sampled at the next negedge.
    task automatic tick();
        if (!Reset_n) model_reset();
        else model_step(KEY, keycode, frame_clk);
        @(negedge Clk);
        check("model", {left, right, shoot, start, cooldown_active},
              {m_left, m_right, m_shoot, m_start, m_cool});
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic frame_pulses(input int n);
        for (int i = 0; i < n; i++) begin
            frame_clk = 1'b1; tick(); tick();
            frame_clk = 1'b0; tick(); tick();
        end
    endtask

    task automatic apply_reset(input logic [2:0] key);
        Reset_n = 1'b0; KEY = key; keycode = 8'h00; frame_clk = 1'b0;
        model_reset();
        ticks(2);
        check("reset_outs", {left, right, shoot, start, cooldown_active}, 8'h00);
        Reset_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0] key;
        logic [7:0] kc;
        logic       exp_left;
        logic       exp_right;
        int         exp_shoots;
        int         exp_starts;
    } vec_t;

    task automatic run_table();
        vec_t vecs[$];
        int   ns, nt;
        vecs.push_back('{3'b111, 8'd0,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{3'b101, 8'd0,  1'b1, 1'b0, 0, 0});
        vecs.push_back('{3'b110, 8'd0,  1'b0, 1'b1, 0, 0});
        vecs.push_back('{3'b100, 8'd0,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{3'b011, 8'd0,  1'b0, 1'b0, 1, 1});
        vecs.push_back('{3'b001, 8'd0,  1'b1, 1'b0, 1, 1});
`ifdef KEYBOARD_INPUT_EN
        vecs.push_back('{3'b111, 8'd4,  1'b1, 1'b0, 0, 0});
        vecs.push_back('{3'b111, 8'd7,  1'b0, 1'b1, 0, 0});
        vecs.push_back('{3'b111, 8'd44, 1'b0, 1'b0, 1, 1});
        vecs.push_back('{3'b111, 8'd40, 1'b0, 1'b0, 0, 1});
        vecs.push_back('{3'b110, 8'd4,  1'b0, 1'b0, 0, 0});
        vecs.push_back('{3'b011, 8'd44, 1'b0, 1'b0, 1, 1});
`else
        vecs.push_back('{3'b111, 8'd44, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{3'b111, 8'd40, 1'b0, 1'b0, 0, 0});
        vecs.push_back('{3'b111, 8'd4,  1'b0, 1'b0, 0, 0});
`endif
        foreach (vecs[i]) begin
            KEY = vecs[i].key; keycode = vecs[i].kc;
            ns = 0; nt = 0;
            for (int k = 0; k < 12; k++) begin
                tick();
                ns += int'(shoot);
                nt += int'(start);
            end
            check($sformatf("vec%0d_left", i), left, vecs[i].exp_left);
            check($sformatf("vec%0d_right", i), right, vecs[i].exp_right);
            check($sformatf("vec%0d_shoots", i), 8'(ns), 8'(vecs[i].exp_shoots));
            check($sformatf("vec%0d_starts", i), 8'(nt), 8'(vecs[i].exp_starts));
            KEY = 3'b111; keycode = 8'h00;
            ticks(8);
            frame_pulses(2);
        end
    endtask

    // ---------------- hand sequences ----------------
    task automatic seq_reset_held();
        apply_reset(3'b000);
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("rst_shoot", shoot, (k == 7));
            check("rst_start", start, (k == 7));
            check("rst_lr", {left, right}, 2'b00);
        end
        check("rst_cool", cooldown_active, 1'b1);
    endtask

    task automatic seq_bounce();
        apply_reset(3'b111);
        ticks(3);
        KEY = 3'b101;
        for (int k = 0; k < 3; k++) begin tick(); check("bounce_early", left, 1'b0); end
        KEY = 3'b111;
        tick(); check("bounce_early", left, 1'b0);
        KEY = 3'b101;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("bounce_left", left, (k >= 6));
        end
    endtask

    task automatic seq_conflict();
        apply_reset(3'b111);
        KEY = 3'b100;
        ticks(10);
        check("conflict_both", {left, right}, 2'b00);
        KEY = 3'b101;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("conflict_left", left, (k >= 6));
            check("conflict_right", right, 1'b0);
        end
    endtask

    task automatic seq_cooldown_button();
        int ns, nt;
        apply_reset(3'b111);
        KEY = 3'b011;
        for (int k = 1; k <= 8; k++) begin tick(); check("cd_first_shot", shoot, (k == 7)); end
        check("cd_active", cooldown_active, 1'b1);
        KEY = 3'b111; ticks(8);
        KEY = 3'b011; ns = 0; nt = 0;
        for (int k = 0; k < 12; k++) begin tick(); ns += int'(shoot); nt += int'(start); end
        check("cd_dropped", 8'(ns), 8'd0);
        check("cd_start_ignores", 8'(nt), 8'd1);
        KEY = 3'b111; ticks(8);
        frame_pulses(1);
        check("cd_after_one_frame", cooldown_active, 1'b1);
        frame_pulses(1);
        check("cd_after_two_frames", cooldown_active, 1'b0);
        KEY = 3'b011;
        for (int k = 1; k <= 8; k++) begin tick(); check("cd_rearmed", shoot, (k == 7)); end
        KEY = 3'b111; ticks(8);
    endtask

    task automatic seq_simultaneous();
        apply_reset(3'b111);
        KEY = 3'b011;
        ticks(4);
        frame_clk = 1'b1;
        ticks(3);
        check("sim_shoot", shoot, 1'b1);
        tick();
        frame_clk = 1'b0;
        ticks(2);
        check("sim_loaded", cooldown_active, 1'b1);
        frame_pulses(1);
        check("sim_count_two", cooldown_active, 1'b1);
        frame_pulses(1);
        check("sim_cleared", cooldown_active, 1'b0);
        KEY = 3'b111; ticks(8);
    endtask

    task automatic seq_reset_mid();
        int ns;
        apply_reset(3'b111);
        KEY = 3'b011; ticks(4);
        apply_reset(3'b111);
        ns = 0;
        for (int k = 0; k < 10; k++) begin tick(); ns += int'(shoot | start); end
        check("reset_mid_no_pulse", 8'(ns), 8'd0);
    endtask

    task automatic seq_keyboard();
        int ns, nt;
        apply_reset(3'b111);
`ifdef KEYBOARD_INPUT_EN
        keycode = 8'd44;
        tick(); check("kc_shoot_n1", shoot, 1'b0);
        tick(); check("kc_shoot_n2", {shoot, start, cooldown_active}, 3'b111);
        keycode = 8'd0; ticks(2);
        keycode = 8'd44; ns = 0;
        for (int k = 0; k < 4; k++) begin tick(); ns += int'(shoot); end
        check("kc_dropped", 8'(ns), 8'd0);
        frame_pulses(2);
        keycode = 8'd0; ticks(2);
        keycode = 8'd44;
        tick(); tick(); check("kc_rearmed", shoot, 1'b1);
        keycode = 8'd4; tick(); check("kc_left", {left, right}, 2'b10);
        keycode = 8'd7; tick(); check("kc_right", {left, right}, 2'b01);
        keycode = 8'd40; tick(); tick(); check("kc_start", {shoot, start}, 2'b01);
        keycode = 8'd0; ticks(4);
`else
        keycode = 8'd44; ns = 0; nt = 0;
        for (int k = 0; k < 100; k++) begin tick(); ns += int'(shoot); nt += int'(start); end
        keycode = 8'd40;
        for (int k = 0; k < 100; k++) begin tick(); ns += int'(shoot); nt += int'(start); end
        check("nokb_shoot", 8'(ns), 8'd0);
        check("nokb_start", 8'(nt), 8'd0);
        KEY = 3'b011;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check("nokb_fire_pulse", {shoot, start}, (k == 7) ? 2'b11 : 2'b00);
        end
        KEY = 3'b111; keycode = 8'd0; ticks(8);
`endif
    endtask

    task automatic run_random(input int n);
        int b;
        apply_reset(3'b111);
        for (int i = 0; i < n; i++) begin
            if (!Reset_n) Reset_n = 1'b1;
            if ($urandom_range(0, 7) == 0) begin
                b = $urandom_range(0, 2);
                KEY[b] = ~KEY[b];
            end
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 5))
                    0: keycode = 8'd0;
                    1: keycode = 8'd4;
                    2: keycode = 8'd7;
                    3: keycode = 8'd40;
                    4: keycode = 8'd44;
                    default: keycode = 8'($urandom);
                endcase
            end
            if ($urandom_range(0, 3) == 0) frame_clk = ~frame_clk;
            if ($urandom_range(0, 499) == 0) Reset_n = 1'b0;
            tick();
        end
        Reset_n = 1'b1;
    endtask

    initial begin
        Reset_n = 1'b0; KEY = 3'b111; keycode = 8'h00; frame_clk = 1'b0;
        model_reset();
        @(negedge Clk);
        seq_reset_held();
        seq_bounce();
        seq_conflict();
        seq_cooldown_button();
        seq_simultaneous();
        seq_reset_mid();
        seq_keyboard();
        apply_reset(3'b111);
        run_table();
        run_random(3000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
